// File: rtl/alu_iq_if.sv
// alu_iq_if -- dispatch, wakeup and issue signals of the ALU issue queue.
//   slave  : seen by the queue (dispatch/wakeup/ready in, full/issue out)
//   master : seen by the dispatch/ALU side that drives the queue
interface alu_iq_if;
  logic       flush_i;
  // dispatch pack
  logic [3:0] pack_id_i;
  logic       ins0_valid_i, ins1_valid_i;
  logic [5:0] ins0_rs1_i, ins0_rs2_i, ins1_rs1_i, ins1_rs2_i;
  logic       ins0_rs1_rdy_i, ins0_rs2_rdy_i, ins1_rs1_rdy_i, ins1_rs2_rdy_i;
  logic       full_o;
  // result-tag wakeup broadcasts
  logic       wb0_valid_i, wb1_valid_i;
  logic [5:0] wb0_tag_i, wb1_tag_i;
  // issue ports
  logic       alu0_valid_o, alu1_valid_o;
  logic [4:0] alu0_rob_o, alu1_rob_o;
  logic       alu0_ready_i, alu1_ready_i;

  modport slave (
    input  flush_i, pack_id_i, ins0_valid_i, ins1_valid_i,
           ins0_rs1_i, ins0_rs2_i, ins1_rs1_i, ins1_rs2_i,
           ins0_rs1_rdy_i, ins0_rs2_rdy_i, ins1_rs1_rdy_i, ins1_rs2_rdy_i,
           wb0_valid_i, wb1_valid_i, wb0_tag_i, wb1_tag_i,
           alu0_ready_i, alu1_ready_i,
    output full_o, alu0_valid_o, alu1_valid_o, alu0_rob_o, alu1_rob_o
  );

  modport master (
    output flush_i, pack_id_i, ins0_valid_i, ins1_valid_i,
           ins0_rs1_i, ins0_rs2_i, ins1_rs1_i, ins1_rs2_i,
           ins0_rs1_rdy_i, ins0_rs2_rdy_i, ins1_rs1_rdy_i, ins1_rs2_rdy_i,
           wb0_valid_i, wb1_valid_i, wb0_tag_i, wb1_tag_i,
           alu0_ready_i, alu1_ready_i,
    input  full_o, alu0_valid_o, alu1_valid_o, alu0_rob_o, alu1_rob_o
  );
endinterface

// File: rtl/alu_iq.sv
// alu_iq -- dual-dispatch, dual-issue collapsing issue queue for two ALUs.
//   cpu_clk_i : clock, all state on rising edge
//   cpu_rst_i : synchronous active-high reset
//   io        : alu_iq_if.slave -- dispatch pack (2 slots), flush, two
//               wakeup tag broadcasts, two issue ports (valid/rob/ready),
//               full_o back-pressure.
// Entries are kept oldest-first at index 0. Each edge, survivors are packed
// toward index 0 and the new pack is appended behind them.
module alu_iq #(
  parameter int DEPTH = 8
) (
  input  logic      cpu_clk_i,
  input  logic      cpu_rst_i,
  alu_iq_if.slave   io
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  typedef struct packed {
    logic       vld;
    logic [4:0] rob;
    logic [5:0] rs1;
    logic       rs1_rdy;
    logic [5:0] rs2;
    logic       rs2_rdy;
  } ent_t;

  ent_t [DEPTH-1:0] q, q_n;
  logic [CW-1:0]    count, cnt_n;
  logic [DEPTH-1:0] elig, rm;
  logic [IW-1:0]    sel0, sel1;
  logic             fnd0, fnd1, fire0, fire1, do_disp;

  function automatic logic hit(input logic [5:0] tag,
                               input logic v0, input logic [5:0] t0,
                               input logic v1, input logic [5:0] t1);
    return (v0 && (t0 == tag)) || (v1 && (t1 == tag));
  endfunction

  assign io.full_o = (count > CW'(DEPTH - 2));
  assign do_disp   = !io.full_o && !io.flush_i && !cpu_rst_i;

  // Eligibility uses registered ready bits only: no same-cycle wakeup bypass.
  always_comb begin
    elig = '0;
    for (int i = 0; i < DEPTH; i++)
      elig[i] = q[i].vld & q[i].rs1_rdy & q[i].rs2_rdy;
  end

  // Oldest and second-oldest eligible entries.
  always_comb begin
    fnd0 = 1'b0; fnd1 = 1'b0; sel0 = '0; sel1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (elig[i] && !fnd0) begin
        fnd0 = 1'b1; sel0 = IW'(i);
      end else if (elig[i] && !fnd1) begin
        fnd1 = 1'b1; sel1 = IW'(i);
      end
    end
  end

  assign io.alu0_valid_o = fnd0;
  assign io.alu1_valid_o = fnd1;
  assign io.alu0_rob_o   = q[sel0].rob;
  assign io.alu1_rob_o   = q[sel1].rob;
  assign fire0 = fnd0 & io.alu0_ready_i;
  assign fire1 = fnd1 & io.alu1_ready_i;

  // Ports retire independently; an unaccepted alu0 pick stays put.
  always_comb begin
    rm = '0;
    for (int i = 0; i < DEPTH; i++)
      rm[i] = (fire0 && (sel0 == IW'(i))) || (fire1 && (sel1 == IW'(i)));
  end

  // Compaction + wakeup + append. cnt_n doubles as the write pointer.
  always_comb begin
    ent_t e;
    e     = '0;
    q_n   = '0;
    cnt_n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q[i].vld && !rm[i]) begin
        e = q[i];
        e.rs1_rdy = e.rs1_rdy | hit(e.rs1, io.wb0_valid_i, io.wb0_tag_i,
                                    io.wb1_valid_i, io.wb1_tag_i);
        e.rs2_rdy = e.rs2_rdy | hit(e.rs2, io.wb0_valid_i, io.wb0_tag_i,
                                    io.wb1_valid_i, io.wb1_tag_i);
        q_n[cnt_n[IW-1:0]] = e;
        cnt_n = cnt_n + 1'b1;
      end
    end
    // Pre-edge count <= DEPTH-2 here, so both slots always fit.
    if (do_disp && io.ins0_valid_i) begin
      e.vld     = 1'b1;
      e.rob     = {io.pack_id_i, 1'b0};
      e.rs1     = io.ins0_rs1_i;
      e.rs2     = io.ins0_rs2_i;
      e.rs1_rdy = io.ins0_rs1_rdy_i | hit(io.ins0_rs1_i, io.wb0_valid_i,
                    io.wb0_tag_i, io.wb1_valid_i, io.wb1_tag_i);
      e.rs2_rdy = io.ins0_rs2_rdy_i | hit(io.ins0_rs2_i, io.wb0_valid_i,
                    io.wb0_tag_i, io.wb1_valid_i, io.wb1_tag_i);
      q_n[cnt_n[IW-1:0]] = e;
      cnt_n = cnt_n + 1'b1;
    end
    if (do_disp && io.ins1_valid_i) begin
      e.vld     = 1'b1;
      e.rob     = {io.pack_id_i, 1'b1};
      e.rs1     = io.ins1_rs1_i;
      e.rs2     = io.ins1_rs2_i;
      e.rs1_rdy = io.ins1_rs1_rdy_i | hit(io.ins1_rs1_i, io.wb0_valid_i,
                    io.wb0_tag_i, io.wb1_valid_i, io.wb1_tag_i);
      e.rs2_rdy = io.ins1_rs2_rdy_i | hit(io.ins1_rs2_i, io.wb0_valid_i,
                    io.wb0_tag_i, io.wb1_valid_i, io.wb1_tag_i);
      q_n[cnt_n[IW-1:0]] = e;
      cnt_n = cnt_n + 1'b1;
    end
  end

  // Flush shares the reset path: drops the queue, dispatch and wakeups.
  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i || io.flush_i) begin
      q     <= '0;
      count <= '0;
    end else begin
      q     <= q_n;
      count <= cnt_n;
    end
  end
endmodule

// File: tb/tb_alu_iq.sv
module tb_alu_iq;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_iq_if bus();
  alu_iq #(.DEPTH(DEPTH)) dut (.cpu_clk_i(clk), .cpu_rst_i(rst), .io(bus.slave));

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: an ordered list of waiting ops, oldest first.
  typedef struct {
    logic [4:0] rob;
    logic [5:0] rs1;
    bit         r1;
    logic [5:0] rs2;
    bit         r2;
  } m_t;
  m_t mq[$];

  function automatic bit mwake(logic [5:0] t);
    return (bus.wb0_valid_i && bus.wb0_tag_i == t) ||
           (bus.wb1_valid_i && bus.wb1_tag_i == t);
  endfunction

  function automatic void mpick(output int i0, output int i1);
    i0 = -1; i1 = -1;
    foreach (mq[k])
      if (mq[k].r1 && mq[k].r2) begin
        if (i0 < 0) i0 = k;
        else if (i1 < 0) i1 = k;
      end
  endfunction

  // One clock: advance the model with the inputs currently driven.
  task automatic tick();
    m_t nq[$];
    m_t e;
    int i0, i1;
    mpick(i0, i1);
    if (!(rst || bus.flush_i)) begin
      foreach (mq[k]) begin
        if (k == i0 && bus.alu0_ready_i) continue;
        if (k == i1 && bus.alu1_ready_i) continue;
        e = mq[k];
        e.r1 = e.r1 | mwake(e.rs1);
        e.r2 = e.r2 | mwake(e.rs2);
        nq.push_back(e);
      end
      if (mq.size() <= DEPTH - 2) begin
        if (bus.ins0_valid_i) begin
          e.rob = {bus.pack_id_i, 1'b0};
          e.rs1 = bus.ins0_rs1_i; e.r1 = bus.ins0_rs1_rdy_i | mwake(bus.ins0_rs1_i);
          e.rs2 = bus.ins0_rs2_i; e.r2 = bus.ins0_rs2_rdy_i | mwake(bus.ins0_rs2_i);
          nq.push_back(e);
        end
        if (bus.ins1_valid_i) begin
          e.rob = {bus.pack_id_i, 1'b1};
          e.rs1 = bus.ins1_rs1_i; e.r1 = bus.ins1_rs1_rdy_i | mwake(bus.ins1_rs1_i);
          e.rs2 = bus.ins1_rs2_i; e.r2 = bus.ins1_rs2_rdy_i | mwake(bus.ins1_rs2_i);
          nq.push_back(e);
        end
      end
    end
    @(posedge clk);
    mq = nq;
    #1;
  endtask

  task automatic clr();
    bus.flush_i = 0; bus.pack_id_i = 0;
    bus.ins0_valid_i = 0; bus.ins1_valid_i = 0;
    bus.ins0_rs1_i = 0; bus.ins0_rs2_i = 0; bus.ins1_rs1_i = 0; bus.ins1_rs2_i = 0;
    bus.ins0_rs1_rdy_i = 0; bus.ins0_rs2_rdy_i = 0;
    bus.ins1_rs1_rdy_i = 0; bus.ins1_rs2_rdy_i = 0;
    bus.wb0_valid_i = 0; bus.wb1_valid_i = 0; bus.wb0_tag_i = 0; bus.wb1_tag_i = 0;
    bus.alu0_ready_i = 0; bus.alu1_ready_i = 0;
  endtask

  task automatic slot0(bit v, logic [5:0] a, bit ar, logic [5:0] b, bit br);
    bus.ins0_valid_i = v; bus.ins0_rs1_i = a; bus.ins0_rs1_rdy_i = ar;
    bus.ins0_rs2_i = b; bus.ins0_rs2_rdy_i = br;
  endtask

  task automatic slot1(bit v, logic [5:0] a, bit ar, logic [5:0] b, bit br);
    bus.ins1_valid_i = v; bus.ins1_rs1_i = a; bus.ins1_rs1_rdy_i = ar;
    bus.ins1_rs2_i = b; bus.ins1_rs2_rdy_i = br;
  endtask

  task automatic do_reset();
    clr(); rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.alu0_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_a0v: got %b want 0", bus.alu0_valid_o); end
    n_checks++; if (bus.alu1_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_a1v: got %b want 0", bus.alu1_valid_o); end
    n_checks++; if (bus.full_o !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", bus.full_o); end
    // Reset mid-operation beats a concurrent dispatch.
    bus.pack_id_i = 5; slot0(1, 1, 1, 2, 1); slot1(1, 3, 1, 4, 1); tick();
    bus.pack_id_i = 6; rst = 1; tick(); rst = 0; clr();
    n_checks++; if (bus.alu0_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_mid_a0v: got %b want 0", bus.alu0_valid_o); end
    n_checks++; if (bus.alu1_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_mid_a1v: got %b want 0", bus.alu1_valid_o); end
  endtask

  task automatic test_basic();
    do_reset();
    bus.pack_id_i = 3; slot0(1, 1, 1, 2, 1); slot1(1, 3, 1, 4, 1); tick(); clr();
    n_checks++; if (bus.alu0_valid_o !== 1'b1 || bus.alu0_rob_o !== 5'd6) begin n_err++; $display("FAIL basic_alu0: got v=%b rob=%0d want v=1 rob=6", bus.alu0_valid_o, bus.alu0_rob_o); end
    n_checks++; if (bus.alu1_valid_o !== 1'b1 || bus.alu1_rob_o !== 5'd7) begin n_err++; $display("FAIL basic_alu1: got v=%b rob=%0d want v=1 rob=7", bus.alu1_valid_o, bus.alu1_rob_o); end
    bus.alu0_ready_i = 1; bus.alu1_ready_i = 1; tick(); clr();
    n_checks++; if (bus.alu0_valid_o !== 1'b0 || bus.alu1_valid_o !== 1'b0) begin n_err++; $display("FAIL basic_drain: got v0=%b v1=%b want 0 0", bus.alu0_valid_o, bus.alu1_valid_o); end
  endtask

  task automatic test_wakeup();
    do_reset();
    bus.pack_id_i = 1; slot0(1, 12, 0, 5, 1); tick(); clr();
    n_checks++; if (bus.alu0_valid_o !== 1'b0) begin n_err++; $display("FAIL wake_before: got %b want 0", bus.alu0_valid_o); end
    bus.wb1_valid_i = 1; bus.wb1_tag_i = 12; tick(); clr();
    n_checks++; if (bus.alu0_valid_o !== 1'b1 || bus.alu0_rob_o !== 5'd2) begin n_err++; $display("FAIL wake_after: got v=%b rob=%0d want v=1 rob=2", bus.alu0_valid_o, bus.alu0_rob_o); end
  endtask

  task automatic test_full();
    do_reset();
    for (int p = 4; p <= 6; p++) begin
      bus.pack_id_i = 4'(p);
      slot0(1, 6'(20 + 2*(p-4)), 0, 0, 1); slot1(1, 6'(21 + 2*(p-4)), 0, 0, 1);
      tick(); clr();
    end
    n_checks++; if (bus.full_o !== 1'b0) begin n_err++; $display("FAIL full_at6: got %b want 0", bus.full_o); end
    bus.pack_id_i = 7; slot0(1, 26, 0, 0, 1); tick(); clr();
    n_checks++; if (bus.full_o !== 1'b1) begin n_err++; $display("FAIL full_at7: got %b want 1", bus.full_o); end
    // Ready-to-go pack offered while full must be dropped.
    bus.pack_id_i = 9; slot0(1, 1, 1, 2, 1); slot1(1, 3, 1, 4, 1); tick(); clr();
    n_checks++; if (bus.full_o !== 1'b1 || bus.alu0_valid_o !== 1'b0) begin n_err++; $display("FAIL full_drop: got full=%b v0=%b want 1 0", bus.full_o, bus.alu0_valid_o); end
    bus.wb0_valid_i = 1; bus.wb0_tag_i = 20; tick(); clr();
    n_checks++; if (bus.alu0_valid_o !== 1'b1 || bus.alu0_rob_o !== 5'd8) begin n_err++; $display("FAIL full_wake: got v=%b rob=%0d want v=1 rob=8", bus.alu0_valid_o, bus.alu0_rob_o); end
    bus.alu0_ready_i = 1; tick(); clr();
    n_checks++; if (bus.full_o !== 1'b0) begin n_err++; $display("FAIL full_release: got %b want 0", bus.full_o); end
  endtask

  task automatic test_indep_ports();
    do_reset();
    bus.pack_id_i = 1; slot0(1, 1, 1, 1, 1); tick(); clr();
    bus.pack_id_i = 4; slot1(1, 1, 1, 1, 1); tick(); clr();
    bus.pack_id_i = 2; slot0(1, 1, 1, 1, 1); tick(); clr();
    n_checks++; if (bus.alu0_rob_o !== 5'd2 || bus.alu1_rob_o !== 5'd9) begin n_err++; $display("FAIL indep_pre: got %0d %0d want 2 9", bus.alu0_rob_o, bus.alu1_rob_o); end
    bus.alu1_ready_i = 1; tick(); clr();
    n_checks++; if (bus.alu0_valid_o !== 1'b1 || bus.alu0_rob_o !== 5'd2) begin n_err++; $display("FAIL indep_alu0: got v=%b rob=%0d want v=1 rob=2", bus.alu0_valid_o, bus.alu0_rob_o); end
    n_checks++; if (bus.alu1_valid_o !== 1'b1 || bus.alu1_rob_o !== 5'd4) begin n_err++; $display("FAIL indep_alu1: got v=%b rob=%0d want v=1 rob=4", bus.alu1_valid_o, bus.alu1_rob_o); end
  endtask

  task automatic test_flush();
    do_reset();
    bus.pack_id_i = 1; slot0(1, 30, 0, 0, 1); slot1(1, 31, 0, 0, 1); tick(); clr();
    bus.pack_id_i = 2; slot0(1, 32, 0, 0, 1); slot1(1, 33, 0, 0, 1); tick(); clr();
    bus.pack_id_i = 3; slot0(1, 34, 0, 0, 1); tick(); clr();
    bus.flush_i = 1; bus.pack_id_i = 12; slot0(1, 1, 1, 1, 1); slot1(1, 1, 1, 1, 1);
    tick(); clr();
    n_checks++; if (bus.alu0_valid_o !== 1'b0 || bus.alu1_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b %b want 0 0", bus.alu0_valid_o, bus.alu1_valid_o); end
    n_checks++; if (bus.full_o !== 1'b0) begin n_err++; $display("FAIL flush_full: got %b want 0", bus.full_o); end
    // Waking the old tags must not resurrect anything.
    bus.wb0_valid_i = 1; bus.wb0_tag_i = 30; bus.wb1_valid_i = 1; bus.wb1_tag_i = 31;
    tick(); clr();
    n_checks++; if (bus.alu0_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_gone: got %b want 0", bus.alu0_valid_o); end
  endtask

  task automatic test_same_cycle_wake();
    do_reset();
    bus.pack_id_i = 10; slot0(1, 3, 1, 17, 0);
    bus.wb0_valid_i = 1; bus.wb0_tag_i = 17; tick(); clr();
    n_checks++; if (bus.alu0_valid_o !== 1'b1 || bus.alu0_rob_o !== 5'd20) begin n_err++; $display("FAIL samewake: got v=%b rob=%0d want v=1 rob=20", bus.alu0_valid_o, bus.alu0_rob_o); end
  endtask

  task automatic test_random();
    int i0, i1;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      clr();
      rst = ($urandom_range(0, 99) == 0);
      bus.flush_i = ($urandom_range(0, 49) == 0);
      bus.pack_id_i = 4'($urandom);
      slot0($urandom_range(0, 2) != 0, 6'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
            6'($urandom_range(0, 7)), $urandom_range(0, 2) == 0);
      slot1($urandom_range(0, 2) != 0, 6'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
            6'($urandom_range(0, 7)), $urandom_range(0, 2) == 0);
      bus.wb0_valid_i = $urandom_range(0, 1); bus.wb0_tag_i = 6'($urandom_range(0, 7));
      bus.wb1_valid_i = $urandom_range(0, 1); bus.wb1_tag_i = 6'($urandom_range(0, 7));
      bus.alu0_ready_i = $urandom_range(0, 1); bus.alu1_ready_i = $urandom_range(0, 1);
      #1;
      mpick(i0, i1);
      n_checks++; if (bus.full_o !== (mq.size() > DEPTH - 2)) begin n_err++; $display("FAIL rnd_full c=%0d: got %b want %b", c, bus.full_o, mq.size() > DEPTH - 2); end
      n_checks++; if (bus.alu0_valid_o !== (i0 >= 0) || (i0 >= 0 && bus.alu0_rob_o !== mq[i0].rob)) begin
        n_err++; $display("FAIL rnd_alu0 c=%0d: got v=%b rob=%0d want v=%b rob=%0d", c, bus.alu0_valid_o, bus.alu0_rob_o, i0 >= 0, (i0 >= 0) ? mq[i0].rob : 5'd0); end
      n_checks++; if (bus.alu1_valid_o !== (i1 >= 0) || (i1 >= 0 && bus.alu1_rob_o !== mq[i1].rob)) begin
        n_err++; $display("FAIL rnd_alu1 c=%0d: got v=%b rob=%0d want v=%b rob=%0d", c, bus.alu1_valid_o, bus.alu1_rob_o, i1 >= 0, (i1 >= 0) ? mq[i1].rob : 5'd0); end
      tick();
    end
    rst = 0; clr();
  endtask

  initial begin
    rst = 1; clr();
    @(negedge clk);
    test_reset();
    test_basic();
    test_wakeup();
    test_full();
    test_indep_ports();
    test_flush();
    test_same_cycle_wake();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/alu_iq.md
ALU_IQ -- requirements
Module: alu_iq

Interface
REQ-001 Parameter DEPTH, default 8, number of issue-queue entries (power of two, >= 4).
REQ-002 cpu_clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 cpu_rst_i  in  1  synchronous, active-high reset.
REQ-004 flush_i  in  1  discard all queued entries (pipeline flush).
REQ-005 pack_id_i  in  4  dispatch pack ID; slot0 ROB ID = {pack_id_i,1'b0}, slot1 ROB ID = {pack_id_i,1'b1}.
REQ-006 ins0_valid_i / ins1_valid_i  in  1 each  dispatch slot valid; slot0 is older than slot1.
REQ-007 ins0_rs1_i, ins0_rs2_i, ins1_rs1_i, ins1_rs2_i  in  6 each  physical source tags.
REQ-008 ins0_rs1_rdy_i, ins0_rs2_rdy_i, ins1_rs1_rdy_i, ins1_rs2_rdy_i  in  1 each  source already available at dispatch.
REQ-009 full_o  out  1  fewer than two free entries; dispatch is ignored while high.
REQ-010 wb0_valid_i, wb1_valid_i  in  1 each; wb0_tag_i, wb1_tag_i  in  6 each  result-tag wakeup broadcasts.
REQ-011 alu0_valid_o, alu1_valid_o  out  1 each  issue request per ALU port.
REQ-012 alu0_rob_o, alu1_rob_o  out  5 each  ROB ID of issued op; drives the instruction-payload RAM read index.
REQ-013 alu0_ready_i, alu1_ready_i  in  1 each  ALU accepts issue this cycle.

Function
REQ-014 Storage: DEPTH entries of {valid, rob[4:0], rs1[5:0], rs1_rdy, rs2[5:0], rs2_rdy}, kept in age order, index 0 oldest (collapsing queue).
REQ-015 count register (log2(DEPTH)+1 bits) holds the number of valid entries; full_o = (count > DEPTH-2), combinational from count.
REQ-016 Dispatch when !full_o && !flush_i && !cpu_rst_i: valid slots appended after surviving entries, slot0 before slot1; ins1 alone is legal and takes one entry.
REQ-017 Wakeup: every valid entry, and every entry being written, sets rsN_rdy when wbK_valid_i and wbK_tag_i == rsN; both wb ports are checked every cycle.
REQ-018 Entry is eligible when valid && rs1_rdy && rs2_rdy using registered state; wakeup at edge N makes it eligible in cycle N+1 (no same-cycle bypass).
REQ-019 Select (combinational): alu0 gets the oldest eligible entry; alu1 gets the second-oldest eligible entry; valid_o low when no such entry.
REQ-020 Removal: entry selected for port P is removed at the edge iff aluP_valid_o && aluP_ready_i; ports are independent, so an unaccepted alu0 pick does not block alu1.
REQ-021 Outputs are held stable while aluP_valid_o && !aluP_ready_i and no older entry becomes eligible.
REQ-022 Compaction: survivors shift toward index 0 with relative age preserved; new dispatches are placed after them in the same edge.
REQ-023 Simultaneous issue and dispatch: full_o uses pre-edge count; next count = count - removed + dispatched, never exceeding DEPTH.
REQ-024 Minimum latency: dispatch with both sources ready at edge N -> aluP_valid_o high in cycle N+1.
REQ-025 flush_i: at the edge, all entries invalid and count = 0; same-cycle dispatch and wakeups are discarded; issue handshakes that cycle are still reported on outputs but have no queue effect.
REQ-026 No pick is issued twice; a removed ROB ID reappears only through a new dispatch.

Reset
REQ-027 cpu_rst_i high at an edge: all entry valid bits 0, count 0; from the next cycle alu0_valid_o = alu1_valid_o = 0 and full_o = 0.
REQ-028 Reset takes priority over flush_i, dispatch and wakeup; reset asserted mid-operation drops all entries.

Verification
REQ-029 Reset, then dispatch pack 3, both slots with all rdy=1 -> next cycle alu0_rob_o=6, alu1_rob_o=7, both valid; with both ready_i=1, the queue is empty one cycle later.
REQ-030 Dispatch slot0 with rs1=12 not ready; pulse wb1_valid_i, wb1_tag_i=12 one cycle later -> alu0_valid_o rises exactly one cycle after the wakeup edge.
REQ-031 Fill to DEPTH-1 entries with non-ready ops -> full_o=1 and a dispatch that cycle is dropped (count unchanged); one issue accepted -> full_o=0 the following cycle.
REQ-032 Three eligible entries with ROB IDs 2, 9, 4 (oldest first) and alu0_ready_i=0, alu1_ready_i=1 -> only 9 is removed; next cycle alu0_rob_o=2, alu1_rob_o=4.
REQ-033 Queue holding 5 entries; flush_i=1 together with a valid dispatch -> count=0, both valid_o low next cycle, dispatched pack absent.
REQ-034 Dispatch where ins0_rs2 matches wb0_tag_i in the same cycle -> entry stored with rs2_rdy=1 and issues the following cycle.
